id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU. Latches decoded operands and control for one instruction per cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives the ALU's A, B and ALUControl inputs, plus the store data and destination info that travel on to EX/MEM.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register-address width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
stall  input  1  hold current contents (load-use / downstream stall)
flush  input  1  replace contents with bubble (branch mispredict)
in_valid  input  1  decode slot holds a real instruction
in_pc  input  XLEN  instruction PC
in_rs1_data  input  XLEN  register-file read port 1
in_rs2_data  input  XLEN  register-file read port 2
in_imm  input  XLEN  sign-extended immediate
in_rs1  input  RA_W  source register 1 index
in_rs2  input  RA_W  source register 2 index
in_rd  input  RA_W  destination index
in_alu_ctrl  input  4  ALU operation code (defines.v encodings)
in_src_a_pc  input  1  1: ALU A = PC, 0: ALU A = rs1
in_src_b_imm  input  1  1: ALU B = imm, 0: ALU B = rs2
in_reg_write  input  1  instruction writes rd
exm_reg_write  input  1  EX/MEM instruction writes back
exm_rd  input  RA_W  EX/MEM destination
exm_result  input  XLEN  EX/MEM ALU result
mwb_reg_write  input  1  MEM/WB instruction writes back
mwb_rd  input  RA_W  MEM/WB destination
mwb_result  input  XLEN  MEM/WB writeback value
alu_a  output  XLEN  ALU operand A (combinational from registered state)
alu_b  output  XLEN  ALU operand B
alu_ctrl  output  4  ALUControl
store_data  output  XLEN  forwarded rs2 value
ex_pc  output  XLEN  registered PC
ex_rd  output  RA_W  registered rd
ex_reg_write  output  1  registered reg_write, gated by valid
ex_valid  output  1  stage holds a real instruction

Behaviour:
- Update priority on each rising clk edge: reset > flush > stall > load.
- Reset: every register cleared to 0.
  - ex_valid=0, ex_reg_write=0, alu_ctrl=`ALU_ADD, ex_rd=0, ex_pc=0.
  - Operand/imm registers are 0, so alu_a=alu_b=store_data=0.
- Flush: same values as reset (bubble), regardless of stall. Reset or flush mid-stall discards the held instruction.
- Load (no stall, no flush):
  - All in_* are captured; latency from capture to outputs is one cycle.
  - ex_reg_write = in_reg_write & in_valid.
- Stall:
  - pc, rs indices, rd, imm, control and valid hold their values.
  - The rs1/rs2 data registers are rewritten with their forwarded values (fwd1/fwd2). A producer that retires from MEM/WB during the stall is therefore not lost.
- Forwarding (combinational from registered rs1/rs2, applied separately to each source):
  - If exm_reg_write and exm_rd==rs and rs!=0, use exm_result.
  - Else if mwb_reg_write and mwb_rd==rs and rs!=0, use mwb_result.
  - Else use the registered data.
  - EX/MEM has priority when both match.
  - x0 never forwards, even if a producer claims rd=0.
- Operand selection:
  - alu_a = src_a_pc ? ex_pc : fwd1
  - alu_b = src_b_imm ? imm : fwd2
  - store_data = fwd2 always, independent of src_b_imm.
  - alu_ctrl = registered code, passed through unmodified.
- With ex_valid=0, outputs still follow registered state (all zero after bubble). Downstream qualifies on ex_valid/ex_reg_write.
- No arithmetic in this block; all muxes are full XLEN width, with no truncation or extension.

Test Plan:
1. Reset → all outputs zero:
   - Assert reset for 2 cycles with arbitrary in_* → ex_valid=0, ex_reg_write=0, alu_a=alu_b=0, alu_ctrl=`ALU_ADD.
2. Plain load, no hazard:
   - Load rs1=3, data 0x10; imm=0x20; src_b_imm=1; ADD → next cycle alu_a=0x10, alu_b=0x20, ex_valid=1.
3. Double hazard, EX/MEM wins:
   - Registered rs1=5 (data 0x1).
   - exm_rd=5, exm_result=0xAAAA, exm_reg_write=1.
   - mwb_rd=5, mwb_result=0xBBBB, mwb_reg_write=1.
   - → alu_a=0xAAAA.
   - Drop exm_reg_write → alu_a=0xBBBB.
4. x0 guard:
   - rs2=0, data 0, src_b_imm=0.
   - exm_rd=0, exm_result=0xDEAD, exm_reg_write=1.
   - → alu_b=0, store_data=0.
5. Stall capture:
   - Registered rs1=7, data 0x1.
   - Stall 2 cycles; during cycle 1, mwb_rd=7 / mwb_result=0x55 / mwb_reg_write=1; in cycle 2 no forwarding.
   - → alu_a=0x55 in both cycles, other outputs unchanged.
   - Release stall → new instruction loads.
6. Flush vs stall:
   - Assert stall and flush together with valid instruction held → next cycle ex_valid=0, ex_reg_write=0, alu_ctrl=`ALU_ADD.
   - Next unstalled cycle loads new instruction normally.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU.
// Holds one decoded instruction, resolves RAW hazards by forwarding from
// EX/MEM and MEM/WB, and presents ALU operands, store data and destination
// info to the execute stage. Supports hold (stall) and bubble (flush).
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RA_W-1:0] in_rs1,
  input  logic [RA_W-1:0] in_rs2,
  input  logic [RA_W-1:0] in_rd,
  input  logic [3:0]      in_alu_ctrl,
  input  logic            in_src_a_pc,
  input  logic            in_src_b_imm,
  input  logic            in_reg_write,
  input  logic            exm_reg_write,
  input  logic [RA_W-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            mwb_reg_write,
  input  logic [RA_W-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_valid
);

  // ADD is the all-zero encoding, so a cleared register reads as ADD.
  localparam logic [3:0] ALU_ADD = 4'b0000;

  // Bypass selection for one source operand. EX/MEM is the younger
  // producer and wins; register x0 is hardwired and never bypassed.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RA_W-1:0] rs,
    input logic [XLEN-1:0] rdata,
    input logic            x_we,
    input logic [RA_W-1:0] x_rd,
    input logic [XLEN-1:0] x_res,
    input logic            w_we,
    input logic [RA_W-1:0] w_rd,
    input logic [XLEN-1:0] w_res
  );
    logic [XLEN-1:0] r;
    r = rdata;
    if (rs != '0) begin
      if (x_we && (x_rd == rs))      r = x_res;
      else if (w_we && (w_rd == rs)) r = w_res;
    end
    return r;
  endfunction

  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] rs1_data_p0;
  logic [XLEN-1:0] rs2_data_p0;
  logic [XLEN-1:0] imm_p0;
  logic [RA_W-1:0] rs1_p0;
  logic [RA_W-1:0] rs2_p0;
  logic [RA_W-1:0] rd_p0;
  logic [3:0]      alu_ctrl_p0;
  logic            src_a_pc_p0;
  logic            src_b_imm_p0;
  logic            reg_write_p0;
  logic            vld_p0;

  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;

  // ---- Stage p0: ID/EX register (reset/flush > stall > load) ----
  // Capture the decoded instruction; during a stall only the operand data
  // is refreshed with its bypassed value so a retiring producer is kept.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pc_p0        <= '0;
      rs1_data_p0  <= '0;
      rs2_data_p0  <= '0;
      imm_p0       <= '0;
      rs1_p0       <= '0;
      rs2_p0       <= '0;
      rd_p0        <= '0;
      alu_ctrl_p0  <= ALU_ADD;
      src_a_pc_p0  <= 1'b0;
      src_b_imm_p0 <= 1'b0;
      reg_write_p0 <= 1'b0;
      vld_p0       <= 1'b0;
    end else if (stall) begin
      rs1_data_p0 <= fwd1;
      rs2_data_p0 <= fwd2;
    end else begin
      pc_p0        <= in_pc;
      rs1_data_p0  <= in_rs1_data;
      rs2_data_p0  <= in_rs2_data;
      imm_p0       <= in_imm;
      rs1_p0       <= in_rs1;
      rs2_p0       <= in_rs2;
      rd_p0        <= in_rd;
      alu_ctrl_p0  <= in_alu_ctrl;
      src_a_pc_p0  <= in_src_a_pc;
      src_b_imm_p0 <= in_src_b_imm;
      reg_write_p0 <= in_reg_write & in_valid;
      vld_p0       <= in_valid;
    end
  end

  // ---- Execute-side outputs: bypass and operand muxes ----
  // Forward each registered source and steer the ALU operand muxes.
  always_comb begin
    fwd1 = fwd_sel(rs1_p0, rs1_data_p0, exm_reg_write, exm_rd, exm_result,
                   mwb_reg_write, mwb_rd, mwb_result);
    fwd2 = fwd_sel(rs2_p0, rs2_data_p0, exm_reg_write, exm_rd, exm_result,
                   mwb_reg_write, mwb_rd, mwb_result);
    alu_a        = src_a_pc_p0  ? pc_p0  : fwd1;
    alu_b        = src_b_imm_p0 ? imm_p0 : fwd2;
    store_data   = fwd2;
    alu_ctrl     = alu_ctrl_p0;
    ex_pc        = pc_p0;
    ex_rd        = rd_p0;
    ex_reg_write = reg_write_p0;
    ex_valid     = vld_p0;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus hand-written sequences.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [3:0]  in_alu_ctrl;
  logic        in_src_a_pc, in_src_b_imm, in_reg_write;
  logic        exm_reg_write, mwb_reg_write;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic [31:0] alu_a, alu_b, store_data, ex_pc;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_valid;

  int n_chk = 0;
  int n_fail = 0;

  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_ctrl(in_alu_ctrl),
    .in_src_a_pc(in_src_a_pc), .in_src_b_imm(in_src_b_imm),
    .in_reg_write(in_reg_write),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .store_data(store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_valid(ex_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, stl, fls, vld;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0] rs1, rs2, rd;
    logic [3:0] ctl;
    logic sa, sb, rw;
    logic xw; logic [4:0] xrd; logic [31:0] xres;
    logic ww; logic [4:0] wrd; logic [31:0] wres;
    logic [31:0] e_a, e_b, e_sd, e_pc;
    logic [4:0] e_rd;
    logic [3:0] e_ctl;
    logic e_rw, e_vld;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_in(input vec_t v);
    reset = v.rst; stall = v.stl; flush = v.fls; in_valid = v.vld;
    in_pc = v.pc; in_rs1_data = v.d1; in_rs2_data = v.d2; in_imm = v.imm;
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd; in_alu_ctrl = v.ctl;
    in_src_a_pc = v.sa; in_src_b_imm = v.sb; in_reg_write = v.rw;
  endtask

  task automatic drive_fwd(input vec_t v);
    exm_reg_write = v.xw; exm_rd = v.xrd; exm_result = v.xres;
    mwb_reg_write = v.ww; mwb_rd = v.wrd; mwb_result = v.wres;
  endtask

  initial begin
    // Field order: rst stl fls vld | pc d1 d2 imm | rs1 rs2 rd ctl | sa sb rw |
    //   xw xrd xres | ww wrd wres | e_a e_b e_sd e_pc e_rd e_ctl e_rw e_vld
    // Bypass fields are applied just after the edge and stay active through
    // the next edge, so they are what a stall in the next vector captures.
    vt[0]  = '{1,0,0,1, 32'h100,32'h1234,32'h5678,32'h9, 5'd1,5'd2,5'd3,4'h7, 1,1,1,
               0,5'd0,32'h0, 0,5'd0,32'h0, 32'h0,32'h0,32'h0,32'h0,5'd0,4'h0,0,0};
    vt[1]  = vt[0];
    vt[2]  = '{0,0,0,1, 32'h40,32'h10,32'h99,32'h20, 5'd3,5'd4,5'd6,4'h0, 0,1,1,
               0,5'd0,32'h0, 0,5'd0,32'h0, 32'h10,32'h20,32'h99,32'h40,5'd6,4'h0,1,1};
    vt[3]  = '{0,0,0,1, 32'h44,32'h1,32'h22,32'h8, 5'd5,5'd2,5'd9,4'h1, 0,0,1,
               1,5'd5,32'hAAAA, 1,5'd5,32'hBBBB, 32'hAAAA,32'h22,32'h22,32'h44,5'd9,4'h1,1,1};
    vt[4]  = '{0,1,0,0, 32'hFFF0,32'hF1,32'hF2,32'hF3, 5'd31,5'd31,5'd31,4'hF, 1,1,0,
               0,5'd5,32'hAAAA, 1,5'd5,32'hBBBB, 32'hBBBB,32'h22,32'h22,32'h44,5'd9,4'h1,1,1};
    vt[5]  = '{0,0,0,1, 32'h80,32'h7,32'h0,32'h0, 5'd1,5'd0,5'd0,4'h2, 1,0,1,
               1,5'd0,32'hDEAD, 1,5'd0,32'hBEEF, 32'h80,32'h0,32'h0,32'h80,5'd0,4'h2,1,1};
    vt[6]  = '{0,0,0,1, 32'h90,32'h1,32'h33,32'h4, 5'd7,5'd8,5'd10,4'h3, 0,1,0,
               0,5'd0,32'h0, 0,5'd0,32'h0, 32'h1,32'h4,32'h33,32'h90,5'd10,4'h3,0,1};
    vt[7]  = '{0,1,0,1, 32'hFFF0,32'hF1,32'hF2,32'hF3, 5'd31,5'd31,5'd31,4'hF, 1,0,1,
               0,5'd0,32'h0, 1,5'd7,32'h55, 32'h55,32'h4,32'h33,32'h90,5'd10,4'h3,0,1};
    vt[8]  = '{0,1,0,1, 32'hFFF0,32'hF1,32'hF2,32'hF3, 5'd31,5'd31,5'd31,4'hF, 1,0,1,
               0,5'd0,32'h0, 0,5'd0,32'h0, 32'h55,32'h4,32'h33,32'h90,5'd10,4'h3,0,1};
    vt[9]  = '{0,0,0,1, 32'hA0,32'h1111,32'h2222,32'h0, 5'd1,5'd2,5'd3,4'h5, 0,0,1,
               0,5'd0,32'h0, 0,5'd0,32'h0, 32'h1111,32'h2222,32'h2222,32'hA0,5'd3,4'h5,1,1};
    vt[10] = '{0,1,1,1, 32'hFFF0,32'hF1,32'hF2,32'hF3, 5'd31,5'd31,5'd31,4'hF, 1,1,1,
               0,5'd0,32'h0, 0,5'd0,32'h0, 32'h0,32'h0,32'h0,32'h0,5'd0,4'h0,0,0};
    vt[11] = '{0,0,0,1, 32'hB0,32'h44,32'h55,32'h7, 5'd4,5'd5,5'd7,4'h6, 0,1,1,
               0,5'd0,32'h0, 0,5'd0,32'h0, 32'h44,32'h7,32'h55,32'hB0,5'd7,4'h6,1,1};
    vt[12] = '{0,0,0,0, 32'hC0,32'h3,32'h0,32'h0, 5'd1,5'd0,5'd2,4'h0, 0,0,1,
               0,5'd0,32'h0, 0,5'd0,32'h0, 32'h3,32'h0,32'h0,32'hC0,5'd2,4'h0,0,0};
    vt[13] = '{0,0,0,1, 32'hD0,32'h0,32'h0,32'h10, 5'd0,5'd6,5'd1,4'h0, 0,1,1,
               0,5'd6,32'h9999, 1,5'd6,32'h6666, 32'h0,32'h10,32'h6666,32'hD0,5'd1,4'h0,1,1};
    vt[14] = '{1,1,0,1, 32'hE0,32'h5,32'h5,32'h5, 5'd1,5'd1,5'd1,4'h4, 1,1,1,
               0,5'd0,32'h0, 0,5'd0,32'h0, 32'h0,32'h0,32'h0,32'h0,5'd0,4'h0,0,0};

    drive_fwd(vt[0]);
    drive_in(vt[0]);
    for (int i = 0; i < NV; i++) begin
      drive_in(vt[i]);
      @(posedge clk);
      #1;
      drive_fwd(vt[i]);
      #1;
      chk($sformatf("v%0d alu_a", i),        alu_a,                 vt[i].e_a);
      chk($sformatf("v%0d alu_b", i),        alu_b,                 vt[i].e_b);
      chk($sformatf("v%0d store_data", i),   store_data,            vt[i].e_sd);
      chk($sformatf("v%0d ex_pc", i),        ex_pc,                 vt[i].e_pc);
      chk($sformatf("v%0d ex_rd", i),        {27'b0, ex_rd},        {27'b0, vt[i].e_rd});
      chk($sformatf("v%0d alu_ctrl", i),     {28'b0, alu_ctrl},     {28'b0, vt[i].e_ctl});
      chk($sformatf("v%0d ex_reg_write", i), {31'b0, ex_reg_write}, {31'b0, vt[i].e_rw});
      chk($sformatf("v%0d ex_valid", i),     {31'b0, ex_valid},     {31'b0, vt[i].e_vld});
    end

    // Double hazard: EX/MEM wins, then MEM/WB, then register data.
    reset = 0; stall = 0; flush = 0; in_valid = 1;
    in_pc = 32'h200; in_rs1 = 5'd5; in_rs1_data = 32'h1; in_rs2 = 5'd3;
    in_rs2_data = 32'h3; in_imm = 32'h0; in_rd = 5'd4; in_alu_ctrl = 4'h0;
    in_src_a_pc = 0; in_src_b_imm = 0; in_reg_write = 1;
    exm_reg_write = 0; mwb_reg_write = 0;
    @(posedge clk);
    #1;
    exm_rd = 5'd5; exm_result = 32'hAAAA; exm_reg_write = 1;
    mwb_rd = 5'd5; mwb_result = 32'hBBBB; mwb_reg_write = 1;
    #1 chk("hz both alu_a", alu_a, 32'hAAAA);
    exm_reg_write = 0;
    #1 chk("hz mwb alu_a", alu_a, 32'hBBBB);
    mwb_reg_write = 0;
    #1 chk("hz none alu_a", alu_a, 32'h1);
    chk("hz none alu_b", alu_b, 32'h3);

    // Flush alone turns a live instruction into a bubble.
    flush = 1;
    @(posedge clk);
    #1;
    chk("flush ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("flush ex_reg_write", {31'b0, ex_reg_write}, 32'h0);
    chk("flush alu_a", alu_a, 32'h0);
    flush = 0;
    @(posedge clk);
    #1;
    chk("after flush ex_pc", ex_pc, 32'h200);
    chk("after flush ex_valid", {31'b0, ex_valid}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
